// File: rtl/cal_abs_pkg.sv
// Shared sizing helpers for the cal_abs magnitude pipeline.
//
// Derives every internal width from DATA_W so the top, the root stages and
// the benches agree on the pipeline geometry.
//
// Compile-time option: CAL_ABS_ROUND_EN adds one round-to-nearest stage
// after the last root stage (one extra cycle of latency).
package cal_abs_pkg;

    // Width of one square.
    function automatic int cal_sq_w(input int data_w);
        return 2 * data_w;
    endfunction

    // Width of the sum of two squares; it cannot overflow.
    function automatic int cal_sum_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

    // Root width: ceil(SUM_W/2).
    function automatic int cal_out_w(input int data_w);
        return data_w + 1;
    endfunction

    // The remainder never exceeds 2*root, so one bit more than the root.
    function automatic int cal_rem_w(input int out_w);
        return out_w + 1;
    endfunction

    // LSB of the radicand bit pair consumed by a root stage (stage 0 = MSB pair).
    function automatic int cal_pair_lsb(input int out_w, input int stage);
        return 2 * (out_w - 1 - stage);
    endfunction

`ifdef CAL_ABS_ROUND_EN
    localparam int ROUND_STAGES = 1;
`else
    localparam int ROUND_STAGES = 0;
`endif

    // Cycles from acceptance to val_o: squares, sum, one stage per root bit,
    // plus the optional rounding stage.
    function automatic int cal_lat(input int data_w);
        return 2 + cal_out_w(data_w) + ROUND_STAGES;
    endfunction

    localparam int LAT = cal_lat(8);

endpackage

// File: rtl/cal_abs_sqrt_stage.sv
// One restoring square-root iteration of the cal_abs pipeline.
//
// Brings down the next radicand bit pair, tries to subtract (4*root + 1)
// and appends the resulting root bit. All outputs are registers that
// advance only while adv is high.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   adv               global pipeline advance (low = hold)
//   cur_val/cur_tag   valid bit and sideband of the incoming sample
//   cur_root/cur_rem  partial root and remainder from the previous stage
//   cur_rad           full radicand, carried along with the sample
//   nxt_*             the same quantities after this iteration
module cal_abs_sqrt_stage
    import cal_abs_pkg::*;
#(
    parameter int OUT_W = 9,
    parameter int TAG_W = 1,
    parameter int STAGE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adv,
    input  logic               cur_val,
    input  logic [TAG_W-1:0]   cur_tag,
    input  logic [OUT_W-1:0]   cur_root,
    input  logic [OUT_W:0]     cur_rem,
    input  logic [2*OUT_W-1:0] cur_rad,
    output logic               nxt_val,
    output logic [TAG_W-1:0]   nxt_tag,
    output logic [OUT_W-1:0]   nxt_root,
    output logic [OUT_W:0]     nxt_rem,
    output logic [2*OUT_W-1:0] nxt_rad
);

    localparam int REM_W = cal_rem_w(OUT_W);
    localparam int SH_W  = REM_W + 2;
    localparam int LSB   = cal_pair_lsb(OUT_W, STAGE);

    logic [SH_W-1:0]  rem_sh;
    logic [SH_W-1:0]  trial;
    logic [SH_W-1:0]  diff;
    logic             take;
    logic [OUT_W-1:0] root_new;
    logic [REM_W-1:0] rem_new;
    logic [1:0]       unused_diff_hi;

    // NOTE: every variable is assigned on every path through this block, so
    // no latch is inferred; a missing else-branch here would create one.
    always_comb begin
        rem_sh   = {cur_rem, cur_rad[LSB +: 2]};
        trial    = {1'b0, cur_root, 2'b01};
        diff     = rem_sh - trial;
        take     = (rem_sh >= trial);
        // The remainder stays <= 2*root, so the top two bits are always zero.
        rem_new  = take ? diff[REM_W-1:0] : rem_sh[REM_W-1:0];
        root_new = {cur_root[OUT_W-2:0], take};
    end

    assign unused_diff_hi = diff[SH_W-1:REM_W];

    // NOTE: the datapath registers are reset along with the valid bits so
    // that the pipeline output reads zero after reset, not stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            nxt_val  <= 1'b0;
            nxt_tag  <= '0;
            nxt_root <= '0;
            nxt_rem  <= '0;
            nxt_rad  <= '0;
        end else if (adv) begin
            nxt_val  <= cur_val;
            nxt_tag  <= cur_tag;
            nxt_root <= root_new;
            nxt_rem  <= rem_new;
            nxt_rad  <= cur_rad;
        end
    end

endmodule

// File: rtl/cal_abs_pipe.sv
// Pipelined complex magnitude: abs_o = floor(sqrt(real_i^2 + imag_i^2)).
//
// Stage S0 registers the two squares, S1 their sum, then OUT_W restoring
// root stages produce one root bit each, MSB first. A single global advance
// (adv = ~val_o | rdy_i) stalls every stage at once while the consumer
// holds off; bubbles are not squeezed out during a stall.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   val_i/rdy_o       input handshake; sample taken when both are high
//   real_i/imag_i     complex sample (two's complement if SIGNED_IN)
//   tag_i             sideband travelling with the sample
//   val_o/rdy_i       output handshake; result taken when both are high
//   abs_o/tag_o       magnitude and its matching sideband
//
// Compile-time option: CAL_ABS_ROUND_EN rounds to nearest through one extra
// stage (latency 3+OUT_W instead of 2+OUT_W).
module cal_abs_pipe
    import cal_abs_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int SIGNED_IN = 1,
    parameter int TAG_W     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              val_i,
    output logic              rdy_o,
    input  logic [DATA_W-1:0] real_i,
    input  logic [DATA_W-1:0] imag_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              val_o,
    input  logic              rdy_i,
    output logic [DATA_W:0]   abs_o,
    output logic [TAG_W-1:0]  tag_o
);

    localparam int SQ_W  = cal_sq_w(DATA_W);
    localparam int SUM_W = cal_sum_w(DATA_W);
    localparam int OUT_W = cal_out_w(DATA_W);
    localparam int REM_W = cal_rem_w(OUT_W);
    localparam int RAD_W = 2 * OUT_W;

    logic adv;

    assign adv   = ~val_o | rdy_i;
    assign rdy_o = adv & ~rst;

    // Extending to SQ_W before multiplying makes the low SQ_W product bits
    // the exact square in both signed and unsigned mode.
    logic            sgn_re;
    logic            sgn_im;
    logic [SQ_W-1:0] re_ext;
    logic [SQ_W-1:0] im_ext;

    always_comb begin
        sgn_re = (SIGNED_IN != 0) && real_i[DATA_W-1];
        sgn_im = (SIGNED_IN != 0) && imag_i[DATA_W-1];
        re_ext = {{DATA_W{sgn_re}}, real_i};
        im_ext = {{DATA_W{sgn_im}}, imag_i};
    end

    logic             s0_val;
    logic [TAG_W-1:0] s0_tag;
    logic [SQ_W-1:0]  s0_sq_re;
    logic [SQ_W-1:0]  s0_sq_im;
    logic             s1_val;
    logic [TAG_W-1:0] s1_tag;
    logic [SUM_W-1:0] s1_sum;

    // NOTE: state is updated with non-blocking assignments so every stage
    // samples its predecessor's old value and the shift happens in lockstep.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_val   <= 1'b0;
            s0_tag   <= '0;
            s0_sq_re <= '0;
            s0_sq_im <= '0;
            s1_val   <= 1'b0;
            s1_tag   <= '0;
            s1_sum   <= '0;
        end else if (adv) begin
            s0_val   <= val_i;
            s0_tag   <= tag_i;
            s0_sq_re <= re_ext * re_ext;
            s0_sq_im <= im_ext * im_ext;
            s1_val   <= s0_val;
            s1_tag   <= s0_tag;
            s1_sum   <= {1'b0, s0_sq_re} + {1'b0, s0_sq_im};
        end
    end

    // Index k feeds root stage k; index OUT_W is the last stage's output.
    logic             val_p  [0:OUT_W];
    logic [TAG_W-1:0] tag_p  [0:OUT_W];
    logic [OUT_W-1:0] root_p [0:OUT_W];
    logic [REM_W-1:0] rem_p  [0:OUT_W];
    logic [RAD_W-1:0] rad_p  [0:OUT_W];

    assign val_p[0]  = s1_val;
    assign tag_p[0]  = s1_tag;
    assign root_p[0] = '0;
    assign rem_p[0]  = '0;
    // Radicand padded by one leading zero to an even number of bits.
    assign rad_p[0]  = {1'b0, s1_sum};

    for (genvar k = 0; k < OUT_W; k++) begin : g_root
        cal_abs_sqrt_stage #(
            .OUT_W (OUT_W),
            .TAG_W (TAG_W),
            .STAGE (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .adv      (adv),
            .cur_val  (val_p[k]),
            .cur_tag  (tag_p[k]),
            .cur_root (root_p[k]),
            .cur_rem  (rem_p[k]),
            .cur_rad  (rad_p[k]),
            .nxt_val  (val_p[k+1]),
            .nxt_tag  (tag_p[k+1]),
            .nxt_root (root_p[k+1]),
            .nxt_rem  (rem_p[k+1]),
            .nxt_rad  (rad_p[k+1])
        );
    end

    logic unused_tail;
    assign unused_tail = ^{rad_p[OUT_W], rem_p[OUT_W]};

`ifdef CAL_ABS_ROUND_EN
    // sqrt(x) >= r + 0.5 exactly when x - r^2 > r; r + 1 still fits OUT_W.
    logic             rnd_up;
    logic             rnd_val;
    logic [TAG_W-1:0] rnd_tag;
    logic [OUT_W-1:0] rnd_abs;

    assign rnd_up = (rem_p[OUT_W] > {1'b0, root_p[OUT_W]});

    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_val <= 1'b0;
            rnd_tag <= '0;
            rnd_abs <= '0;
        end else if (adv) begin
            rnd_val <= val_p[OUT_W];
            rnd_tag <= tag_p[OUT_W];
            rnd_abs <= root_p[OUT_W] + {{(OUT_W-1){1'b0}}, rnd_up};
        end
    end

    assign val_o = rnd_val;
    assign tag_o = rnd_tag;
    assign abs_o = rnd_abs;
`else
    assign val_o = val_p[OUT_W];
    assign tag_o = tag_p[OUT_W];
    assign abs_o = root_p[OUT_W];
`endif

endmodule

// File: tb/tb_cal_abs_pipe.sv
// Self-checking bench for cal_abs_pipe: directed vector table on the signed
// 8-bit instance, corner samples on unsigned 8-bit and signed 12-bit
// instances, random streaming, backpressure and mid-stream reset, with a
// scoreboard on the signed 8-bit instance.
module tb_cal_abs_pipe;
    import cal_abs_pkg::*;

    localparam int LAT8  = cal_lat(8);
    localparam int LAT12 = cal_lat(12);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Signed 8-bit instance (scoreboarded)
    logic       val_i = 1'b0, rdy_i = 1'b1, rdy_o, val_o;
    logic [7:0] real_i = '0, imag_i = '0;
    logic       tag_i = 1'b0, tag_o;
    logic [8:0] abs_o;

    cal_abs_pipe #(.DATA_W(8), .SIGNED_IN(1), .TAG_W(1)) dut (
        .clk(clk), .rst(rst), .val_i(val_i), .rdy_o(rdy_o),
        .real_i(real_i), .imag_i(imag_i), .tag_i(tag_i),
        .val_o(val_o), .rdy_i(rdy_i), .abs_o(abs_o), .tag_o(tag_o)
    );

    // Unsigned 8-bit instance
    logic       u_val_i = 1'b0, u_rdy_o, u_val_o;
    logic [7:0] u_re = '0, u_im = '0;
    logic       u_tag_i = 1'b0, u_tag_o;
    logic [8:0] u_abs;

    cal_abs_pipe #(.DATA_W(8), .SIGNED_IN(0), .TAG_W(1)) dut_u (
        .clk(clk), .rst(rst), .val_i(u_val_i), .rdy_o(u_rdy_o),
        .real_i(u_re), .imag_i(u_im), .tag_i(u_tag_i),
        .val_o(u_val_o), .rdy_i(1'b1), .abs_o(u_abs), .tag_o(u_tag_o)
    );

    // Signed 12-bit instance
    logic        w_val_i = 1'b0, w_rdy_o, w_val_o;
    logic [11:0] w_re = '0, w_im = '0;
    logic [1:0]  w_tag_i = '0, w_tag_o;
    logic [12:0] w_abs;

    cal_abs_pipe #(.DATA_W(12), .SIGNED_IN(1), .TAG_W(2)) dut_w (
        .clk(clk), .rst(rst), .val_i(w_val_i), .rdy_o(w_rdy_o),
        .real_i(w_re), .imag_i(w_im), .tag_i(w_tag_i),
        .val_o(w_val_o), .rdy_i(1'b1), .abs_o(w_abs), .tag_o(w_tag_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Golden magnitude: integer square root by search, optional rounding.
    function automatic longint mag_ref(input longint re, input longint im);
        longint x = re * re + im * im;
        longint r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
`ifdef CAL_ABS_ROUND_EN
        if (x - r * r > r) r++;
`endif
        return r;
    endfunction

    // Scoreboard on the signed 8-bit instance
    typedef struct {
        longint abs_v;
        logic   tag;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   mon_e;
    longint cyc        = 0;
    longint first_out  = -1;
    longint last_out   = -1;
    int     out_cnt    = 0;
    int     in_cnt     = 0;
    logic   acc_last   = 1'b0;
    logic   stall_prev = 1'b0;
    logic [8:0] stall_abs;
    logic       stall_tag;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb_q.delete();
            stall_prev = 1'b0;
            acc_last   = 1'b0;
            check("rdy_o_in_reset", rdy_o, 0);
        end else begin
            check("rdy_o_rule", rdy_o, (!val_o || rdy_i));
            if (stall_prev) begin
                check("stall_val_hold", val_o, 1);
                check("stall_abs_hold", abs_o, stall_abs);
                check("stall_tag_hold", tag_o, stall_tag);
            end
            acc_last = val_i && rdy_o;
            if (acc_last) begin
                sb_q.push_back('{mag_ref($signed(real_i), $signed(imag_i)), tag_i});
                in_cnt++;
            end
            if (val_o && rdy_i) begin
                out_cnt++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                check("sb_has_entry", (sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check("sb_abs", abs_o, mon_e.abs_v);
                    check("sb_tag", tag_o, mon_e.tag);
                end
            end
            stall_prev = val_o && !rdy_i;
            stall_abs  = abs_o;
            stall_tag  = tag_o;
        end
    end

    task automatic drain();
        int n = 0;
        val_i = 1'b0;
        rdy_i = 1'b1;
        while ((sb_q.size() != 0 || val_o) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string name, input logic [7:0] re, input logic [7:0] im,
                            input logic tg, input longint exp_abs);
        int lat;
        @(posedge clk); #1;
        val_i = 1'b1; real_i = re; imag_i = im; tag_i = tg; rdy_i = 1'b1;
        @(negedge clk);
        check({name, "_rdy_o"}, rdy_o, 1);
        @(posedge clk); #1;
        val_i = 1'b0;
        lat = 1;
        while (!val_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, lat, LAT8);
        check({name, "_abs"}, abs_o, exp_abs);
        check({name, "_tag"}, tag_o, tg);
    endtask

    task automatic send_u(input string name, input logic [7:0] re, input logic [7:0] im,
                          input longint exp_abs);
        int lat;
        @(posedge clk); #1;
        u_val_i = 1'b1; u_re = re; u_im = im; u_tag_i = 1'b1;
        @(posedge clk); #1;
        u_val_i = 1'b0;
        lat = 1;
        while (!u_val_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, lat, LAT8);
        check({name, "_abs"}, u_abs, exp_abs);
        check({name, "_tag"}, u_tag_o, 1);
    endtask

    task automatic send_w(input string name, input logic [11:0] re, input logic [11:0] im,
                          input longint exp_abs);
        int lat;
        @(posedge clk); #1;
        w_val_i = 1'b1; w_re = re; w_im = im; w_tag_i = 2'b10;
        @(posedge clk); #1;
        w_val_i = 1'b0;
        lat = 1;
        while (!w_val_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, lat, LAT12);
        check({name, "_abs"}, w_abs, exp_abs);
        check({name, "_tag"}, w_tag_o, 2);
    endtask

    typedef struct {
        string      name;
        logic [7:0] re;
        logic [7:0] im;
        logic       tag;
        longint     exp_abs;
    } vec_t;

    vec_t vecs[9];
    int   bp_pat[7] = '{1, 1, 0, 0, 0, 1, 0};

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vecs[0] = '{"v3_4",      8'sd3,    8'sd4,    1'b1, 5};
        vecs[1] = '{"v0_0",      8'sd0,    8'sd0,    1'b0, 0};
        vecs[2] = '{"vmin_min",  -8'sd128, -8'sd128, 1'b1, 181};
        vecs[3] = '{"vmax_min",  8'sd127,  -8'sd128, 1'b0, 180};
        vecs[4] = '{"v5_m12",    8'sd5,    -8'sd12,  1'b1, 13};
        vecs[5] = '{"vm7_24",    -8'sd7,   8'sd24,   1'b0, 25};
        vecs[6] = '{"v1_1",      8'sd1,    8'sd1,    1'b1, 1};
`ifdef CAL_ABS_ROUND_EN
        vecs[7] = '{"v2_2",      8'sd2,    8'sd2,    1'b0, 3};
        vecs[8] = '{"vmax_max",  8'sd127,  8'sd127,  1'b1, 180};
`else
        vecs[7] = '{"v2_2",      8'sd2,    8'sd2,    1'b0, 2};
        vecs[8] = '{"vmax_max",  8'sd127,  8'sd127,  1'b1, 179};
`endif

        // Reset
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_val_o", val_o, 0);
        check("reset_abs_o", abs_o, 0);
        check("reset_tag_o", tag_o, 0);

        // Directed table, one sample at a time
        for (int i = 0; i < 9; i++) begin
            send_one(vecs[i].name, vecs[i].re, vecs[i].im, vecs[i].tag, vecs[i].exp_abs);
        end
        drain();

        // Unsigned and wide corners
`ifdef CAL_ABS_ROUND_EN
        send_u("u255_255", 8'd255, 8'd255, 361);
`else
        send_u("u255_255", 8'd255, 8'd255, 360);
`endif
        send_u("u255_0", 8'd255, 8'd0, 255);
        send_w("w_min_min", 12'h800, 12'h800, 2896);
        drain();

        // Full-rate streaming
        out_cnt = 0;
        first_out = -1;
        for (int i = 0; i < 1024; i++) begin
            @(posedge clk); #1;
            val_i = 1'b1; rdy_i = 1'b1;
            real_i = 8'($urandom); imag_i = 8'($urandom); tag_i = 1'($urandom);
        end
        @(posedge clk); #1;
        val_i = 1'b0;
        drain();
        check("stream_count", out_cnt, 1024);
        check("stream_contiguous", last_out - first_out, 1023);

        // Backpressure with random input valid
        out_cnt = 0;
        in_cnt = 0;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk); #1;
            rdy_i = bp_pat[c % 7][0];
            if (!val_i || acc_last) begin
                val_i  = 1'($urandom);
                real_i = 8'($urandom); imag_i = 8'($urandom); tag_i = 1'($urandom);
            end
        end
        drain();
        check("bp_in_out_count", out_cnt, in_cnt);

        // Reset with six samples in flight
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            val_i = 1'b1; rdy_i = 1'b1;
            real_i = 8'($urandom); imag_i = 8'($urandom); tag_i = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        val_i = 1'b0;
        check("midrst_val_o", val_o, 0);
        check("midrst_abs_o", abs_o, 0);
        check("midrst_tag_o", tag_o, 0);
        out_cnt = 0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_ghost", out_cnt, 0);

        // Stream after reset
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            val_i = 1'b1; rdy_i = 1'b1;
            real_i = 8'($urandom); imag_i = 8'($urandom); tag_i = 1'($urandom);
        end
        @(posedge clk); #1;
        val_i = 1'b0;
        drain();
        check("post_rst_count", out_cnt, 50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
